// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter and its helpers.
package freq_meter_pkg;
  localparam int FM_CNT_W  = 9;
  localparam int FM_CNT_MAX = 511;
  localparam int FM_LOCK_W = 4;

  typedef enum logic [1:0] {IDLE, MEAS, LOST} fm_state_e;

  // Saturating increment shared by the period and high-time counters.
  function automatic logic [FM_CNT_W-1:0] fm_sat_inc(input logic [FM_CNT_W-1:0] v);
    return (v == FM_CNT_W'(FM_CNT_MAX)) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/freq_meter_sync_2ff.sv
// Generic 2-flop synchronizer, async active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic s1_q, s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;
endmodule

// File: rtl/freq_meter.sv
// Period meter for a divided clock: divisor readback with valid/lock/timeout.
// Optional high-time measurement enabled by FREQ_METER_DUTY_EN.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int MAX_PERIOD = 256
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clk_in,
  output logic [7:0] div_meas,
  output logic       meas_valid,
  output logic       locked,
  output logic       timeout
`ifdef FREQ_METER_DUTY_EN
  ,
  output logic [8:0] high_meas
`endif
);
  localparam logic [FM_CNT_W-1:0]  MAXP   = FM_CNT_W'(MAX_PERIOD);
  localparam logic [FM_LOCK_W-1:0] LOCK_N = FM_LOCK_W'(LOCK_CNT);

  logic s2, s3_q, rise;
  logic [FM_CNT_W-1:0] cnt_q, cnt_d;
  fm_state_e state_q, state_d;
  logic do_meas, do_to;
  logic [7:0] div_q, div_d;
  logic [FM_LOCK_W-1:0] lock_q, lock_d;
  logic meas_valid_q, locked_q, timeout_q, timeout_d;

  sync_2ff u_sync (.clk(clk), .rst_n(rstn), .d_i(clk_in), .q_o(s2));

  assign rise  = s2 & ~s3_q;
  assign cnt_d = rise ? FM_CNT_W'(1) : fm_sat_inc(cnt_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise) state_d = MEAS;
      MEAS:    if (do_to) state_d = LOST;
      LOST:    if (rise) state_d = MEAS;
      default: state_d = IDLE;
    endcase
  end

  // A rise in the same cycle as the limit wins over the timeout.
  always_comb begin
    do_meas = (state_q == MEAS) && rise && (cnt_q >= FM_CNT_W'(2)) && (cnt_q <= MAXP);
    do_to   = (state_q == MEAS) && !rise && (cnt_q == MAXP);
  end

  always_comb begin
    div_d     = div_q;
    lock_d    = lock_q;
    timeout_d = timeout_q;
    if (do_meas) begin
      div_d = cnt_q[7:0] - 8'd1;
      if (div_d == div_q) lock_d = (lock_q == LOCK_N) ? lock_q : lock_q + 1'b1;
      else                lock_d = FM_LOCK_W'(1);
    end
    if (do_to) begin
      lock_d    = '0;
      timeout_d = 1'b1;
    end else if (state_q == LOST && rise) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s3_q         <= 1'b0;
      cnt_q        <= '0;
      div_q        <= '0;
      lock_q       <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      s3_q         <= s2;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      lock_q       <= lock_d;
      meas_valid_q <= do_meas;
      locked_q     <= (lock_d == LOCK_N);
      timeout_q    <= timeout_d;
    end
  end

  assign div_meas   = div_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;

`ifdef FREQ_METER_DUTY_EN
  logic [FM_CNT_W-1:0] hcnt_q, hcnt_d, high_q;

  // The rise cycle itself is the first high cycle of the new period.
  assign hcnt_d = rise ? FM_CNT_W'(1) : (s2 ? fm_sat_inc(hcnt_q) : hcnt_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hcnt_q <= '0;
      high_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      if (do_meas) high_q <= hcnt_q;
    end
  end

  assign high_meas = high_q;
`endif
endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: directed scenarios plus random periods.
module tb_freq_meter;
  localparam int LOCK = 4;
  localparam int MAXP = 256;

  logic clk = 1'b0, rstn = 1'b0, clk_in_drv = 1'b0, bypass = 1'b0;
  logic clk_in;
  logic [7:0] div_meas;
  logic meas_valid, locked, timeout;
`ifdef FREQ_METER_DUTY_EN
  logic [8:0] high_meas;
`endif

  assign clk_in = bypass ? clk : clk_in_drv;

  freq_meter #(.LOCK_CNT(LOCK), .MAX_PERIOD(MAXP)) dut (
    .clk(clk), .rstn(rstn), .clk_in(clk_in),
    .div_meas(div_meas), .meas_valid(meas_valid), .locked(locked), .timeout(timeout)
`ifdef FREQ_METER_DUTY_EN
    , .high_meas(high_meas)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed events
  int got_div[$], got_lck[$], got_cyc[$], got_to[$];
  bit to_prev = 1'b0, lock_seen = 1'b0;
  always @(negedge clk) begin
    if (meas_valid) begin
      got_div.push_back(int'(div_meas));
      got_lck.push_back(int'(locked));
      got_cyc.push_back(cyc);
    end
    if (timeout && !to_prev) got_to.push_back(cyc);
    to_prev = timeout;
    if (bypass && locked) lock_seen = 1'b1;
  end

  // Reference model: edge times -> expected measurements and timeouts
  int exp_div[$], exp_lck[$], exp_cyc[$], exp_to[$];
  bit m_ref, m_todone;
  int m_last, m_run, m_div;
  int ntests = 0, nfail = 0;

  task automatic chk(input string tag, input int got, input int exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ref = 0; m_todone = 0; m_last = 0; m_run = 0; m_div = 0;
  endtask

  task automatic edge_model(input int rc);
    int p, d;
    if (!m_ref) begin
      m_ref = 1; m_last = rc; m_todone = 0;
      return;
    end
    p = rc - m_last;
    if (p > MAXP) begin
      if (!m_todone) exp_to.push_back(m_last + MAXP + 2);
      m_run = 0;
    end else begin
      d = p - 1;
      m_run = (d == m_div) ? ((m_run + 1 > LOCK) ? LOCK : m_run + 1) : 1;
      m_div = d;
      exp_div.push_back(d);
      exp_lck.push_back(int'(m_run == LOCK));
      exp_cyc.push_back(rc + 2);
    end
    m_last = rc;
    m_todone = 0;
  endtask

  task automatic drive(input int p, input int h);
    @(negedge clk);
    clk_in_drv = 1'b1;
    edge_model(cyc + 1);
    repeat (h - 1) @(negedge clk);
    @(negedge clk);
    clk_in_drv = 1'b0;
    repeat (p - h - 1) @(negedge clk);
  endtask

  task automatic clear_q();
    got_div.delete(); got_lck.delete(); got_cyc.delete(); got_to.delete();
    exp_div.delete(); exp_lck.delete(); exp_cyc.delete(); exp_to.delete();
  endtask

  task automatic check_all(input string sc);
    int n;
    repeat (4) @(negedge clk);
    if (m_ref && !m_todone && cyc >= m_last + MAXP + 2) begin
      exp_to.push_back(m_last + MAXP + 2);
      m_todone = 1;
    end
    @(negedge clk);
    chk({sc, ".n_meas"}, got_div.size(), exp_div.size());
    chk({sc, ".n_timeout"}, got_to.size(), exp_to.size());
    n = (got_div.size() < exp_div.size()) ? got_div.size() : exp_div.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.div[%0d]", sc, i), got_div[i], exp_div[i]);
      chk($sformatf("%s.locked[%0d]", sc, i), got_lck[i], exp_lck[i]);
      chk($sformatf("%s.cycle[%0d]", sc, i), got_cyc[i], exp_cyc[i]);
    end
    n = (got_to.size() < exp_to.size()) ? got_to.size() : exp_to.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s.to_cycle[%0d]", sc, i), got_to[i], exp_to[i]);
    clear_q();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    clk_in_drv = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    clear_q();
    rstn = 1'b1;
  endtask

  initial begin
    int p, h;
    model_reset();
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst.div", int'(div_meas), 0);
    chk("rst.valid", int'(meas_valid), 0);
    chk("rst.locked", int'(locked), 0);
    chk("rst.timeout", int'(timeout), 0);
    do_reset();

    // Period 5, high 3
    repeat (6) drive(5, 3);
`ifdef FREQ_METER_DUTY_EN
    chk("p5.high", int'(high_meas), 3);
`endif
    check_all("p5");

    // Period 256, then a stretched gap forcing a timeout and recovery
    repeat (5) drive(256, 128);
    repeat (10) @(negedge clk);
    chk("p256.timeout_set", int'(timeout), 1);
    chk("p256.locked_drop", int'(locked), 0);
    repeat (5) drive(256, 128);
    chk("p256.timeout_clr", int'(timeout), 0);
    check_all("p256");

    // Period 10 -> 7 after lock
    repeat (6) drive(10, 5);
    repeat (6) drive(7, 3);
    check_all("p10_7");

    // Randomized periods, including some beyond MAX_PERIOD
    p = 6;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) >= 7) begin
        case ($urandom_range(0, 3))
          0: p = 3;
          1: p = 6;
          2: p = 11;
          default: p = $urandom_range(2, 300);
        endcase
      end
      h = $urandom_range(1, p - 1);
      drive(p, h);
    end
    check_all("rand");

    // Static input after reset, then a single edge
    do_reset();
    repeat (600) @(negedge clk);
    check_all("static");
    chk("static.timeout", int'(timeout), 0);
    drive(2, 1);
    repeat (300) @(negedge clk);
    check_all("single");
    chk("single.timeout", int'(timeout), 1);

    // Reset mid-period while locked, then period 3
    do_reset();
    repeat (6) drive(20, 10);
    chk("midrst.locked_before", int'(locked), 1);
    @(negedge clk);
    clk_in_drv = 1'b1;
    edge_model(cyc + 1);
    repeat (5) @(negedge clk);
    #1;
    rstn = 1'b0;
    clk_in_drv = 1'b0;
    #1;
    chk("midrst.div", int'(div_meas), 0);
    chk("midrst.valid", int'(meas_valid), 0);
    chk("midrst.locked", int'(locked), 0);
    chk("midrst.timeout", int'(timeout), 0);
    check_all("pre_rst");
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) drive(3, 1);
    check_all("p3");

    // Bypass: clk_in follows clk
    do_reset();
    lock_seen = 1'b0;
    bypass = 1'b1;
    repeat (1000) @(negedge clk);
    bypass = 1'b0;
    chk("bypass.never_locked", int'(lock_seen), 0);
    clear_q();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/freq_meter.md
# freq_meter

Measures the divisor of a divided clock produced by the team's clock divider (or any slow periodic signal) by counting `clk` cycles between consecutive rising edges of the synchronized input. It sits beside the divider as its checker/readback path: the divider's output comes in on `clk_in`, and the block returns the equivalent 8-bit divisor plus valid, lock and timeout status for software and for self-test.

## Interface
- `LOCK_CNT`, default 4: number of consecutive identical measurements required before `locked` asserts (range 2..15).
- `MAX_PERIOD`, default 256: longest legal period in `clk` cycles. A longer gap between edges is a timeout. Range 2..510.
- `clk` input 1: reference clock (fastest clock). All state is in this domain.
- `rstn` input 1: asynchronous reset, active-low.
- `clk_in` input 1: signal under measurement. Asynchronous to `clk`, 2-flop synchronized internally.
- `div_meas` output 8: last measured divisor (= period − 1).
- `meas_valid` output 1: one-cycle pulse when `div_meas` updates.
- `locked` output 1: `LOCK_CNT` consecutive equal measurements have been seen.
- `timeout` output 1: no rising edge within `MAX_PERIOD` cycles. Sticky until the next detected edge.
- `high_meas` output 9: only with `FREQ_METER_DUTY_EN`. `clk` cycles with synchronized `clk_in` high in the last period.

## Operation
- Synchronizer: `clk_in` → s1 → s2. Prev flop s3 <= s2. Edge `rise = s2 & ~s3`.
- Period counter `cnt`, 9 bits:
  - Loads 1 on `rise`, otherwise increments.
  - Saturates at 511, so it never wraps.
- State machine, reset state IDLE:
  - IDLE: waits for `rise`. On `rise`, go to MEAS with `cnt` <= 1 and no measurement output (the first edge is only a reference).
  - MEAS, on `rise`: period = `cnt`. If 2 <= period <= `MAX_PERIOD`, then `div_meas` <= period − 1 (low 8 bits) and pulse `meas_valid`. Stay in MEAS.
  - MEAS, no `rise` and `cnt` == `MAX_PERIOD`: go to LOST. Set `timeout` <= 1, `locked` <= 0, lock counter <= 0.
  - LOST, on `rise`: `timeout` <= 0, `cnt` <= 1, go to MEAS. No measurement on this edge.
- Lock counter, 4 bits:
  - On each `meas_valid`, if the new `div_meas` equals the previous one, increment, saturating at `LOCK_CNT`. Otherwise it loads 1.
  - `locked` = lock counter == `LOCK_CNT`, registered. A mismatching measurement drops `locked` in the same update.
- `div_meas` holds its last value through LOST. Only `meas_valid` indicates fresh data.
- A full-rate `clk_in` (divider bypass, divisor 0) aliases after synchronization. The block then reports either no edges (timeout) or unstable values and never asserts `locked`. This is the expected result for that case.

## Timing
- Reset values: `div_meas` 0, `meas_valid` 0, `locked` 0, `timeout` 0, `high_meas` 0, state IDLE, all sync flops 0.
- Latency: let edge k be the first `clk` edge that samples `clk_in` = 1.
  - `rise` is true during the cycle after edge k+1.
  - `meas_valid`/`div_meas` are registered at edge k+2 and visible after it.
- `meas_valid` is exactly one cycle wide. The minimum spacing is 2 cycles (the minimum resolvable period).
- Timeout at the same edge as `rise`: `rise` wins, and no timeout is raised.
- `rstn` asserted mid-period: all state clears immediately, and the first edge after release is a reference edge only.
- `locked` can rise no earlier than the `LOCK_CNT`-th `meas_valid` after IDLE or LOST, on the same edge as that pulse.

## Configuration
- `FREQ_METER_DUTY_EN` defined:
  - A 9-bit high counter increments while s2 = 1 and is cleared on `rise`, with the same saturation as `cnt`.
  - Its value is captured into `high_meas` on every `meas_valid`.
- `FREQ_METER_DUTY_EN` undefined: the counter and the `high_meas` port do not exist.

## Structure
- Package `freq_meter_pkg`:
  - State enum (IDLE, MEAS, LOST).
  - `FM_CNT_W` = 9.
  - `FM_CNT_MAX` = 511.
  - `FM_LOCK_W` = 4.
- Sub-module `sync_2ff`: a generic 2-flop synchronizer with async active-low reset to 0. It is reused for other async inputs.

## Test plan
- Reset, then a clean `clk_in` with period 5 (high 3, low 2): the first `meas_valid` comes on the second rising edge with `div_meas` = 4. With DUTY_EN, `high_meas` = 3. `locked` = 1 on the 4th pulse.
- Drive from a divider model with divisor 255 (period 256): `div_meas` = 255, no timeout. Stretch one period to 257: `timeout` = 1 after 256 cycles, `locked` = 0, then recovery through LOST → MEAS.
- Switch period 10 → 7 mid-stream after lock: `locked` drops on the first `div_meas` = 6 pulse, and re-locks after 4 pulses at 6.
- Hold `clk_in` static for 600 cycles after reset: stays in IDLE with no timeout and no `meas_valid`. After the first edge it then times out at `cnt` = 256.
- Assert `rstn` mid-period while locked: all outputs 0 immediately. After release, period 3 gives `div_meas` = 2 on the second edge only.
- Feed `clk_in` = `clk` (bypass): `locked` never asserts over 1000 cycles.
